peripheral_servo_ctrl: RTL and testbench
========================================

# peripheral_servo_ctrl

Parametrised multi-channel servo/motion PWM peripheral on the J1 I/O bus. It generalises the fixed two-axis position registers into N channels with per-channel target and current positions, and generates one hobby-servo PWM output per channel. Optional slew-rate ramping moves each channel toward its target once per frame. It provides busy status and a sticky "motion done" interrupt. It sits behind the CPU address decoder, selected by `cs`, and its PWM outputs drive the pan/tilt actuators.

## Interface
- `NUM_CH`, 2: number of channels, 1..8.
- `PRESC`, 50: clk cycles per 1 µs tick.
- `PERIOD_US`, 20000: PWM frame length in µs.
- `MIN_US`, 1000: minimum pulse width, used as the clamp floor.
- `MAX_US`, 2000: maximum pulse width, used as the clamp ceiling.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `d_in` in 16: write data.
- `cs` in 1: peripheral select.
- `addr` in 4: low 4 bits of the I/O address.
- `rd` in 1: read strobe.
- `wr` in 1: write strobe.
- `d_out` out 16: registered read data.
- `pwm` out NUM_CH: servo pulse outputs, one bit per channel.
- `irq` out 1: level interrupt.

## Operation
- Register map. Any other address reads 0 and ignores writes.
  - 0x0 CTRL (R/W): bit0 EN, bit1 RAMP, bit2 IRQ_EN. Other bits read 0.
  - 0x2 STATUS (R, plus W1C on bit14): bits[NUM_CH-1:0] BUSY, where channel cur ≠ target. Bit14 DONE. Bit15 EN echo.
  - 0x4 SEL (R/W): bits[2:0] select the channel.
  - 0x6 TARGET (R/W): target of channel SEL. Write data is clamped to [MIN_US, MAX_US].
  - 0x8 CURRENT (R): current pulse width of channel SEL.
  - 0xA STEP (R/W): ramp step in µs per frame.
- If SEL ≥ NUM_CH, TARGET/CURRENT writes are ignored and reads return 0.
- Prescaler: `pcnt` counts 0..PRESC-1. `tick` is asserted when `pcnt` = PRESC-1.
- Frame counter: `us_cnt` counts 0..PERIOD_US-1 and advances on `tick`.
- `frame_end` = `tick` && `us_cnt` = PERIOD_US-1.
- While EN=0, `pcnt` and `us_cnt` are held at 0 and `pwm` = 0.
- When EN goes 0→1, a new frame starts at `us_cnt` = 0.
- `pwm[i]` = EN && (`us_cnt` < cur[i]), registered.
- Cur update happens only at `frame_end`, for each channel:
  - If RAMP=0 or STEP=0: cur = target.
  - Otherwise, if |target−cur| ≤ STEP: cur = target.
  - Otherwise: cur ± STEP, toward target.
  - The difference is computed in 17-bit unsigned-safe arithmetic, so there is no wrap.
- DONE is set at the `frame_end` where BUSY goes from non-zero to all-zero.
  - DONE is cleared by writing 0x2 with bit14 = 1.
  - If set and clear occur in the same cycle, set wins.
- `irq` = IRQ_EN && DONE.

## Timing
- Reset values:
  - CTRL, SEL, STEP, DONE, `pcnt`, `us_cnt`: 0.
  - `pwm`, `irq`, `d_out`: 0.
  - All target and cur: (MIN_US+MAX_US)/2.
- Reset is asynchronous. It forces all outputs low immediately, including mid-frame or mid-ramp.
- Write: takes effect at the rising edge where `cs`&&`wr`.
- Read: `d_out` is loaded at the rising edge where `cs`&&`rd`, giving 1-cycle latency. `d_out` holds its value otherwise.
- Simultaneous `rd`&&`wr` to the same address: the read returns the pre-write value.
- Writing TARGET mid-frame does not alter the pulse in progress. It takes effect at the next `frame_end`, or gradually under RAMP.
- A `pwm` edge lags the `us_cnt` compare by 1 cycle.
- Frame length is exactly PRESC·PERIOD_US cycles.

## Test plan
Bench parameters: PRESC=2, PERIOD_US=100, MIN_US=10, MAX_US=50, NUM_CH=2.
- Reset, then read 0x6 and 0x8 for SEL=0 → 30 and 30. Read 0x0 → 0. `pwm` = 0.
- Write EN=1 → `pwm[0]` is high for 60 cycles of each 200-cycle frame.
- Write TARGET=5 → reads back 10. Write TARGET=99 → reads back 50.
- SEL=1, RAMP=1, STEP=7, IRQ_EN=1, TARGET=50 → CURRENT reads 37, 44, 50 after successive frames.
  - BUSY[1] is 1 until the third frame_end.
  - At the third frame_end, DONE and `irq` go to 1.
  - Write 0x2 with 0x4000 → `irq` = 0.
- Write SEL=3 then TARGET=40 → no change to any channel. Reading 0x6 gives 0.
- Assert `rst` mid-ramp at `us_cnt`=20 → `pwm` and `irq` drop to 0 without waiting for a clock edge. After release, all registers are at their reset values.

Source files
------------

// File: rtl/peripheral_servo_ctrl_if.sv
// peripheral_servo_ctrl_if: J1 I/O bus slice plus servo outputs for the servo controller
interface peripheral_servo_ctrl_if #(
  parameter int NUM_CH = 2
);
  logic [15:0] d_in;
  logic [15:0] d_out;
  logic [3:0] addr;
  logic cs;
  logic rd;
  logic wr;
  logic [NUM_CH-1:0] pwm;
  logic irq;
  modport master (output d_in, addr, cs, rd, wr, input d_out, pwm, irq);
  modport slave (input d_in, addr, cs, rd, wr, output d_out, pwm, irq);
endinterface

// File: rtl/peripheral_servo_ctrl.sv
// peripheral_servo_ctrl: N-channel hobby-servo PWM with per-frame slew ramping and motion-done irq
module peripheral_servo_ctrl #(
  parameter int NUM_CH = 2,
  parameter int PRESC = 50,
  parameter int PERIOD_US = 20000,
  parameter int MIN_US = 1000,
  parameter int MAX_US = 2000
) (
  input logic clk,
  input logic rst,
  peripheral_servo_ctrl_if.slave bus_io
);
  localparam logic [15:0] MID = 16'((MIN_US + MAX_US) / 2);
  localparam logic [15:0] LO = 16'(MIN_US);
  localparam logic [15:0] HI = 16'(MAX_US);
  logic [2:0] ctrl_q, ctrl_d, sel_q, sel_d;
  logic [15:0] step_q, step_d, pcnt_q, pcnt_d, us_q, us_d, d_out_q, d_out_d;
  logic done_q, done_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [15:0] tgt_q [NUM_CH];
  logic [15:0] tgt_d [NUM_CH];
  logic [15:0] cur_q [NUM_CH];
  logic [15:0] cur_d [NUM_CH];
  logic [16:0] diff [NUM_CH];
  logic en, ramp, tick, frame_end, we, any_busy_d;
  logic [13:0] busy;
  logic [15:0] tgt_sel, cur_sel, clamped, rdata;
  assign en = ctrl_q[0];
  assign ramp = ctrl_q[1];
  assign tick = en && pcnt_q == 16'(PRESC - 1);
  assign frame_end = tick && us_q == 16'(PERIOD_US - 1);
  assign we = bus_io.cs && bus_io.wr;
  assign clamped = bus_io.d_in < LO ? LO : bus_io.d_in > HI ? HI : bus_io.d_in;
  always_comb begin
    busy = '0;
    tgt_sel = '0;
    cur_sel = '0;
    any_busy_d = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      tgt_d[i] = (we && bus_io.addr == 4'h6 && sel_q == 3'(i)) ? clamped : tgt_q[i];
      // 17-bit magnitude so the step comparison never wraps
      diff[i] = tgt_q[i] >= cur_q[i] ? {1'b0, tgt_q[i]} - {1'b0, cur_q[i]}
                                     : {1'b0, cur_q[i]} - {1'b0, tgt_q[i]};
      cur_d[i] = !frame_end ? cur_q[i]
               : (!ramp || step_q == '0 || diff[i] <= {1'b0, step_q}) ? tgt_q[i]
               : tgt_q[i] > cur_q[i] ? cur_q[i] + step_q : cur_q[i] - step_q;
      busy[i] = cur_q[i] != tgt_q[i];
      any_busy_d |= cur_d[i] != tgt_d[i];
      tgt_sel = sel_q == 3'(i) ? tgt_q[i] : tgt_sel;
      cur_sel = sel_q == 3'(i) ? cur_q[i] : cur_sel;
      pwm_d[i] = en && us_q < cur_q[i];
    end
    done_d = (frame_end && |busy && !any_busy_d)
          || (done_q && !(we && bus_io.addr == 4'h2 && bus_io.d_in[14]));
    ctrl_d = (we && bus_io.addr == 4'h0) ? bus_io.d_in[2:0] : ctrl_q;
    sel_d = (we && bus_io.addr == 4'h4) ? bus_io.d_in[2:0] : sel_q;
    step_d = (we && bus_io.addr == 4'hA) ? bus_io.d_in : step_q;
    pcnt_d = (!en || tick) ? '0 : pcnt_q + 16'd1;
    us_d = (!en || frame_end) ? '0 : tick ? us_q + 16'd1 : us_q;
    rdata = bus_io.addr == 4'h0 ? {13'b0, ctrl_q}
          : bus_io.addr == 4'h2 ? {en, done_q, busy}
          : bus_io.addr == 4'h4 ? {13'b0, sel_q}
          : bus_io.addr == 4'h6 ? tgt_sel
          : bus_io.addr == 4'h8 ? cur_sel
          : bus_io.addr == 4'hA ? step_q : '0;
    d_out_d = (bus_io.cs && bus_io.rd) ? rdata : d_out_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      sel_q <= '0;
      step_q <= '0;
      done_q <= 1'b0;
      pcnt_q <= '0;
      us_q <= '0;
      pwm_q <= '0;
      d_out_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_q[i] <= MID;
        cur_q[i] <= MID;
      end
    end else begin
      ctrl_q <= ctrl_d;
      sel_q <= sel_d;
      step_q <= step_d;
      done_q <= done_d;
      pcnt_q <= pcnt_d;
      us_q <= us_d;
      pwm_q <= pwm_d;
      d_out_q <= d_out_d;
      tgt_q <= tgt_d;
      cur_q <= cur_d;
    end
  end
  assign bus_io.d_out = d_out_q;
  assign bus_io.pwm = pwm_q;
  assign bus_io.irq = ctrl_q[2] && done_q;
endmodule

// File: tb/tb_peripheral_servo_ctrl.sv
// tb_peripheral_servo_ctrl: directed checks of registers, PWM duty, ramping, irq and async reset
module tb_peripheral_servo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [15:0] r;
  int hi;
  peripheral_servo_ctrl_if #(.NUM_CH(2)) bus ();
  peripheral_servo_ctrl #(.NUM_CH(2), .PRESC(2), .PERIOD_US(100), .MIN_US(10), .MAX_US(50)) dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.d_in = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask
  task automatic rd(input logic [3:0] a, output logic [15:0] d);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.cs = 1'b0; bus.rd = 1'b0;
    d = bus.d_out;
  endtask
  task automatic rdchk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    logic [15:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask
  task automatic wait_frame();
    logic prev;
    logic found;
    prev = bus.pwm[0];
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      found = !prev && bus.pwm[0];
      prev = bus.pwm[0];
    end
    chk("frame_timeout", {15'b0, found}, 16'd1);
  endtask
  initial begin
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.d_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_pwm", {14'b0, bus.pwm}, 16'd0);
    chk("rst_irq", {15'b0, bus.irq}, 16'd0);
    chk("rst_dout", bus.d_out, 16'd0);
    rdchk("rst_target", 4'h6, 16'd30);
    rdchk("rst_current", 4'h8, 16'd30);
    rdchk("rst_ctrl", 4'h0, 16'd0);
    rdchk("bad_addr", 4'hC, 16'd0);
    wr(4'h0, 16'h0001);
    hi = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      hi += int'(bus.pwm[0]);
    end
    chk("duty_ch0", 16'(hi), 16'd60);
    wait_frame();
    wr(4'h6, 16'd5);
    rdchk("clamp_lo", 4'h6, 16'd10);
    wr(4'h6, 16'd99);
    rdchk("clamp_hi", 4'h6, 16'd50);
    rdchk("cur_midframe", 4'h8, 16'd30);
    rdchk("status_busy0", 4'h2, 16'h8001);
    wait_frame();
    rdchk("cur_jump", 4'h8, 16'd50);
    rdchk("status_done", 4'h2, 16'hC000);
    wr(4'h2, 16'h4000);
    rdchk("status_clr", 4'h2, 16'h8000);
    wr(4'h4, 16'd1);
    wr(4'hA, 16'd7);
    wr(4'h0, 16'h0007);
    wr(4'h6, 16'd50);
    chk("irq_idle", {15'b0, bus.irq}, 16'd0);
    rdchk("status_busy1", 4'h2, 16'h8002);
    wait_frame();
    rdchk("ramp1", 4'h8, 16'd37);
    chk("irq_ramp1", {15'b0, bus.irq}, 16'd0);
    wait_frame();
    rdchk("ramp2", 4'h8, 16'd44);
    rdchk("status_ramp2", 4'h2, 16'h8002);
    wait_frame();
    rdchk("ramp3", 4'h8, 16'd50);
    chk("irq_done", {15'b0, bus.irq}, 16'd1);
    rdchk("status_ramp3", 4'h2, 16'hC000);
    wr(4'h2, 16'h4000);
    chk("irq_cleared", {15'b0, bus.irq}, 16'd0);
    wr(4'h4, 16'd3);
    wr(4'h6, 16'd40);
    rdchk("sel3_target", 4'h6, 16'd0);
    rdchk("sel3_current", 4'h8, 16'd0);
    wr(4'h4, 16'd1);
    rdchk("ch1_untouched", 4'h6, 16'd50);
    wr(4'h4, 16'd0);
    rdchk("ch0_untouched", 4'h6, 16'd50);
    wr(4'h4, 16'd1);
    wr(4'h6, 16'd43);
    wait_frame();
    chk("irq_one_step", {15'b0, bus.irq}, 16'd1);
    wr(4'h6, 16'd10);
    wait_frame();
    repeat (40) @(negedge clk);
    chk("pre_rst_pwm", {14'b0, bus.pwm}, 16'd3);
    chk("pre_rst_irq", {15'b0, bus.irq}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_pwm", {14'b0, bus.pwm}, 16'd0);
    chk("async_irq", {15'b0, bus.irq}, 16'd0);
    chk("async_dout", bus.d_out, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rdchk("post_ctrl", 4'h0, 16'd0);
    rdchk("post_sel", 4'h4, 16'd0);
    rdchk("post_step", 4'hA, 16'd0);
    rdchk("post_status", 4'h2, 16'd0);
    rdchk("post_target0", 4'h6, 16'd30);
    rdchk("post_current0", 4'h8, 16'd30);
    wr(4'h4, 16'd1);
    rdchk("post_target1", 4'h6, 16'd30);
    rdchk("post_current1", 4'h8, 16'd30);
    chk("post_pwm", {14'b0, bus.pwm}, 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
